register_file_32x32: RTL
========================

# register_file_32x32

Thirty-two-entry, 32-bit general-purpose register file built around the hardwired-zero $R0 stage. It sits between instruction decode and the ALU operand latches. It provides two registered read ports and one write-back port. A per-register pending-write scoreboard flags operands whose producer has issued but not yet written back.

## Interface
- `DEPTH`, 32, number of registers; the address width is log2(DEPTH)
- `WIDTH`, 32, data width in bits
- `Clk`  in  1  clock; all state updates on the rising edge
- `Rst`  in  1  synchronous reset, active-high
- `Ard1`  in  5  read port 1 address
- `Ard2`  in  5  read port 2 address
- `Awr`  in  5  write-back address
- `Din`  in  32  write-back data
- `WrEn`  in  1  write-back strobe
- `Iss`  in  1  issue strobe; marks `Aiss` pending
- `Aiss`  in  5  destination address of the issuing instruction
- `Dout1`  out  32  registered read data, port 1
- `Dout2`  out  32  registered read data, port 2
- `Busy1`  out  1  registered; `Dout1` is stale because a write to `Ard1` is outstanding
- `Busy2`  out  1  registered; `Dout2` is stale because a write to `Ard2` is outstanding
- `PendCnt`  out  6  number of registers currently pending (0..31)

## Operation
- Storage: registers 1..31 are flops. Register 0 is the zero stage; it reads as 0 and cannot be written or marked pending.
- Write: on a rising edge with `WrEn`=1 and `Awr`≠0, `reg[Awr]`←`Din`. The same edge clears `pend[Awr]`. When `Awr`=0 the write is ignored silently.
- Issue: on a rising edge with `Iss`=1 and `Aiss`≠0, `pend[Aiss]`←1. An issue with `Aiss`=0 is a no-op.
- Simultaneous write and issue to the same address: the data is written and `pend` stays 1, because the new producer wins.
- Write-back to a non-pending register: the data is written and `pend` stays 0. This is legal.
- Issue to an already-pending register: `pend` stays 1 and `PendCnt` is unchanged.
- Read: each edge captures `reg[ArdN]` into `DoutN` and `pend[ArdN]` into `BusyN`. Which state is captured (before or after this edge's write) depends on the configuration.
- Read of address 0: `DoutN`=0 and `BusyN`=0 always.
- Both ports may read the same address. They then return identical data.
- `PendCnt` tracks the population count of `pend`, updated at the same edge as `pend`: +1, −1, or 0 per edge. Simultaneous set of one register and clear of another gives a net 0.
- Reset: all registers clear to 0, `pend` clears to all zeros, and `Dout1`, `Dout2`, `Busy1`, `Busy2` and `PendCnt` become 0. A reset asserted mid-operation overrides any concurrent `WrEn` or `Iss` on that edge.

## Timing
- Read latency is 1 cycle. Addresses presented before edge N produce data and busy flags on the outputs after edge N, held stable until edge N+1.
- A write presented before edge N is visible to reads addressed before edge N+1 in all configurations.
- The visibility of a write from the same cycle depends on `REGFILE_BYPASS_EN`; see Configuration.
- No combinational path exists from inputs to outputs. All outputs come directly from flops.
- With `Rst`=1 at edge N, outputs are 0 after edge N. Normal operation resumes at the first edge with `Rst`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through forwarding is enabled.
  - If `WrEn`=1, `Awr`≠0 and `ArdN`=`Awr` at edge N, then `DoutN`=`Din` after edge N.
  - `BusyN` reflects `pend` after this edge's update. A write-back clears busy in the same cycle; a simultaneous issue to the same address sets it.
- `REGFILE_BYPASS_EN` undefined: reads capture the pre-edge state.
  - Under the same conditions, `DoutN` holds the old `reg[Awr]`, and `BusyN` holds the old `pend[Awr]`.
  - Decode must stall one extra cycle after write-back.

## Test plan
- Reset then read all addresses: `Rst`=1 for 2 cycles, then sweep `Ard1`/`Ard2` over 0..31 -> every `Dout`=0, every `Busy`=0, `PendCnt`=0.
- R0 protection: write `Awr`=0 with `Din`=0xDEADBEEF, and issue `Aiss`=0 -> reading address 0 gives 0 and `Busy`=0; `PendCnt` stays 0.
- Basic write/read: write r5=0x12345678 and r31=0xFFFFFFFF, then read `Ard1`=5 and `Ard2`=31 on the next cycle -> `Dout1`=0x12345678 and `Dout2`=0xFFFFFFFF, one cycle after the addresses.
- Same-cycle write and read of r7: r7 holds 0x11, then in one cycle write `Din`=0x22 with `Ard1`=7.
  - Bypass build: `Dout1`=0x22.
  - Non-bypass build: `Dout1`=0x11, and 0x22 on the following read.
- Scoreboard flow:
  - Issue r3 -> `PendCnt`=1 and reading r3 gives `Busy1`=1.
  - Write-back r3 in the same cycle as issuing r3 again -> `pend[3]` stays 1 and `PendCnt` stays 1.
  - Write-back r3 alone -> `PendCnt`=0 and `Busy` is clear.
- Reset mid-operation: with r9 pending and `WrEn`=1 to r9 on the reset edge -> after that edge, reading r9 gives 0, `Busy`=0 and `PendCnt`=0.

Source files
------------

// File: rtl/register_file_32x32_if.sv
// Port bundle for register_file_32x32: read addresses, write-back, issue and registered read results.
interface register_file_32x32_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    Ard1;
    logic [AW-1:0]    Ard2;
    logic [AW-1:0]    Awr;
    logic [WIDTH-1:0] Din;
    logic             WrEn;
    logic             Iss;
    logic [AW-1:0]    Aiss;
    logic [WIDTH-1:0] Dout1;
    logic [WIDTH-1:0] Dout2;
    logic             Busy1;
    logic             Busy2;
    logic [CW-1:0]    PendCnt;

    modport master (
        output Ard1, Ard2, Awr, Din, WrEn, Iss, Aiss,
        input  Dout1, Dout2, Busy1, Busy2, PendCnt
    );

    modport slave (
        input  Ard1, Ard2, Awr, Din, WrEn, Iss, Aiss,
        output Dout1, Dout2, Busy1, Busy2, PendCnt
    );
endinterface

// File: rtl/register_file_32x32.sv
// 32x32 register file with hardwired-zero r0, two registered read ports and a pending-write scoreboard.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module register_file_32x32 #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input logic                 Clk,
    input logic                 Rst,
    register_file_32x32_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             wr_hit;
    logic             iss_hit;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy1_c;
    logic             busy2_c;
    logic [WIDTH-1:0] dout1_q;
    logic [WIDTH-1:0] dout2_q;
    logic             busy1_q;
    logic             busy2_q;

    assign wr_hit  = bus.WrEn && (bus.Awr != '0);
    assign iss_hit = bus.Iss && (bus.Aiss != '0);

    // Issue is applied after write-back so a same-address issue keeps the entry pending.
    always_comb begin
        pend_nxt = pend;
        if (wr_hit) begin
            pend_nxt[bus.Awr] = 1'b0;
        end
        if (iss_hit) begin
            pend_nxt[bus.Aiss] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Incremental popcount: a set only counts on a 0->1 change, a clear only on a 1->0 change.
    always_comb begin
        cnt_inc = iss_hit && !pend[bus.Aiss];
        cnt_dec = wr_hit && pend[bus.Awr] && !(iss_hit && (bus.Aiss == bus.Awr));
        cnt_nxt = cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_comb begin
        rd1     = '0;
        rd2     = '0;
        busy1_c = 1'b0;
        busy2_c = 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (bus.Ard1 != '0) begin
            rd1     = (wr_hit && (bus.Ard1 == bus.Awr)) ? bus.Din : regs[bus.Ard1];
            busy1_c = pend_nxt[bus.Ard1];
        end
        if (bus.Ard2 != '0) begin
            rd2     = (wr_hit && (bus.Ard2 == bus.Awr)) ? bus.Din : regs[bus.Ard2];
            busy2_c = pend_nxt[bus.Ard2];
        end
`else
        if (bus.Ard1 != '0) begin
            rd1     = regs[bus.Ard1];
            busy1_c = pend[bus.Ard1];
        end
        if (bus.Ard2 != '0) begin
            rd2     = regs[bus.Ard2];
            busy2_c = pend[bus.Ard2];
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend    <= '0;
            cnt     <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[bus.Awr] <= bus.Din;
            end
            pend    <= pend_nxt;
            cnt     <= cnt_nxt;
            dout1_q <= rd1;
            dout2_q <= rd2;
            busy1_q <= busy1_c;
            busy2_q <= busy2_c;
        end
    end

    assign bus.Dout1   = dout1_q;
    assign bus.Dout2   = dout2_q;
    assign bus.Busy1   = busy1_q;
    assign bus.Busy2   = busy2_q;
    assign bus.PendCnt = cnt;
endmodule
